// File: rtl/spi_pkg.sv
// Shared constants and types for the register-config SPI controller.
// Frame layout, MSB first: {rw, addr[6:0], data[7:0]}, rw = 1 for a write.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_RW_BIT  = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_master_state_e;

  // Packed so the latched request doubles as the outgoing frame.
  typedef struct packed {
    logic                  we;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] wdata;
  } spi_req_t;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI controller: emits a one-cycle phase_end_o tick
// every CLK_DIV cycles while en_i is high, and sits at zero while disabled.
// Every controller phase is exactly CLK_DIV cycles long, so clearing the
// counter on each tick reloads it at every phase change.
module spi_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic phase_end_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign phase_end_o = en_i && (cnt_q == LAST);

  // Free-running phase count, cleared when idle or at the end of a phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || phase_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Controller end of the 4-wire register-config SPI link (mode 0, 16-bit frame).
// Optional build macro: SPI_MASTER_MISO_SYNC_EN adds a 2-FF synchroniser on
// miso_i ahead of the sample point; without it miso_i is sampled directly.
// CLK_DIV must be >= 4 (peripheral uses a 3-FF synchroniser on SCLK).
//
// Request handshake: a request transfers on the rising clk_i edge where
// req_valid_i && req_ready_o. req_ready_o is high only in IDLE; the request
// fields are captured on that edge and not looked at again for the frame.
// rsp_valid_o is a one-cycle pulse with no back-pressure.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [SPI_ADDR_W-1:0] req_addr_i,
  input  logic [SPI_DATA_W-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [SPI_DATA_W-1:0] rsp_rdata_o,
  output logic                  busy_o,
  output logic                  sclk_o,
  output logic                  cs_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output spi_master_state_e     dbg_state_o
);

  spi_master_state_e      state_q, state_d;
  spi_req_t               req;
  logic                   we_q;
  logic [SPI_FRAME_W-1:0] tx_q;
  logic [SPI_DATA_W-1:0]  rx_q;
  logic [4:0]             bit_cnt_q;
  logic                   sclk_q;
  logic                   rsp_valid_q;
  logic [SPI_DATA_W-1:0]  rsp_rdata_q;
  logic                   phase_end;
  logic                   accept;
  logic                   active;
  logic                   miso_s;

  assign req         = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i};
  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign active      = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign busy_o      = (state_q != IDLE);
  // CS falls already in the accept cycle, so a held request sees CS high
  // for exactly the CLK_DIV GAP cycles between frames.
  assign cs_o        = !(active || accept);
  assign sclk_o      = sclk_q;
  assign mosi_o      = tx_q[SPI_FRAME_W-1];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign dbg_state_o = state_q;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;

  // Two-stage synchroniser; the sample sits at the end of a CLK_DIV-long
  // high phase, so the two-cycle delay stays inside the stable window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miso_sync_q <= 2'b00;
    end else begin
      miso_sync_q <= {miso_sync_q[0], miso_i};
    end
  end

  assign miso_s = miso_sync_q[1];
`else
  assign miso_s = miso_i;
`endif

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (state_q != IDLE),
    .phase_end_o (phase_end)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: each phase lasts one divider period; SHIFT leaves after
  // the low half of bit 0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = SETUP;
      SETUP:   if (phase_end) state_d = SHIFT;
      SHIFT:   if (phase_end && !sclk_q && (bit_cnt_q == 5'd0)) state_d = HOLD;
      HOLD:    if (phase_end) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: SCLK toggling, MOSI shifting on SCLK fall, MISO capture
  // at the end of each high half, and the response pulse on GAP entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= 5'd0;
      sclk_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q      <= req.we;
            tx_q      <= req;
            bit_cnt_q <= 5'd15;
            sclk_q    <= 1'b0;
          end
        end
        SETUP: begin
          if (phase_end) sclk_q <= 1'b1;
        end
        SHIFT: begin
          if (phase_end) begin
            if (sclk_q) begin
              sclk_q <= 1'b0;
              rx_q   <= {rx_q[SPI_DATA_W-2:0], miso_s};
              if (bit_cnt_q != 5'd0) tx_q <= {tx_q[SPI_FRAME_W-2:0], 1'b0};
            end else if (bit_cnt_q != 5'd0) begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              sclk_q    <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : rx_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master at CLK_DIV=4 with a behavioural mode-0
// peripheral holding a 128x8 register file.
module tb_spi_master;
  import spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int BOUND   = 400;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_we_i = 1'b0;
  logic [6:0]        req_addr_i = '0;
  logic [7:0]        req_wdata_i = '0;
  logic              rsp_valid_o;
  logic [7:0]        rsp_rdata_o;
  logic              busy_o;
  logic              sclk_o;
  logic              cs_o;
  logic              mosi_o;
  logic              miso_i = 1'b0;
  spi_master_state_e dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // peripheral model state
  logic [7:0]  mem [128];
  logic [15:0] p_sh = '0;
  int          p_cnt = 0;
  logic        p_rw = 1'b0;
  logic [6:0]  p_addr = '0;
  logic [15:0] mosi_cap = '0;
  int          wr_cnt = 0;
  logic [6:0]  wr_addr_q[$];

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .busy_o      (busy_o),
    .sclk_o      (sclk_o),
    .cs_o        (cs_o),
    .mosi_o      (mosi_o),
    .miso_i      (miso_i),
    .dbg_state_o (dbg_state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // peripheral: shift MOSI on SCLK rise, commit a complete write on CS rise
  always @(posedge sclk_o or posedge cs_o) begin
    if (cs_o) begin
      if (p_cnt == 16) begin
        mosi_cap = p_sh;
        if (p_rw) begin
          mem[p_addr] = p_sh[7:0];
          wr_cnt++;
          wr_addr_q.push_back(p_addr);
        end
      end
      p_cnt = 0;
    end else begin
      p_sh = {p_sh[14:0], mosi_o};
      p_cnt++;
      if (p_cnt == 8) begin
        p_rw   = p_sh[7];
        p_addr = p_sh[6:0];
      end
    end
  end

  // peripheral: present read data on SCLK fall during bits 7..0
  always @(negedge sclk_o) begin
    logic [7:0] rd;
    if (!cs_o && !p_rw && p_cnt >= 8 && p_cnt < 16) begin
      rd = mem[p_addr];
      miso_i = rd[15-p_cnt];
    end
  end

  // scoreboard: every response pops one expected read value
  always @(negedge clk_i) begin
    logic [7:0] e;
    if (rst_ni === 1'b1 && rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_rdata", {24'd0, rsp_rdata_o}, {24'd0, e});
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready_o !== 1'b1 && n < BOUND) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(n < BOUND), 32'd1);
  endtask

  // one complete request; measures response and ready-return latency
  task automatic send(input string tag, input logic we, input logic [6:0] addr,
                      input logic [7:0] wd, input logic [7:0] exp_rd);
    int n;
    int lat_rsp;
    int lat_rdy;
    exp_q.push_back(exp_rd);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    wait_ready(tag);
    @(posedge clk_i);  // accept edge T
    #1 req_valid_i = 1'b0;
    n = 0; lat_rsp = 0; lat_rdy = 0;
    while (lat_rdy == 0 && n < BOUND) begin
      @(posedge clk_i);
      n++;
      #1;
      if (rsp_valid_o && lat_rsp == 0) lat_rsp = n;
      if (req_ready_o) lat_rdy = n;
    end
    // pulse set by edge T+34*CLK_DIV, ready back after edge T+35*CLK_DIV
    check({tag, "_lat_rsp"}, lat_rsp, 34 * CLK_DIV);
    check({tag, "_lat_rdy"}, lat_rdy, 35 * CLK_DIV);
  endtask

  initial begin
    int n;
    int hi;
    int rdy_hi;
    int extra_acc;
    int base;
    logic seen;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h12] = 8'h3C;
    mem[7'h7F] = 8'hFF;

    // reset
    rst_ni = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", 32'(rsp_rdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sclk", 32'(sclk_o), 32'd0);
    check("rst_cs", 32'(cs_o), 32'd1);
    check("rst_mosi", 32'(mosi_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(IDLE));
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1: write 0x05 <= 0xA5
    send("wr05", 1'b1, 7'h05, 8'hA5, 8'h00);
    check("wr05_mosi", 32'(mosi_cap), 32'h85A5);
    check("wr05_wr_cnt", wr_cnt, 1);
    check("wr05_mem", 32'(mem[7'h05]), 32'hA5);
    check("wr05_rdata", 32'(rsp_rdata_o), 32'h00);

    // 2: read 0x12 (preloaded 0x3C)
    send("rd12", 1'b0, 7'h12, 8'h5F, 8'h3C);
    check("rd12_mosi_hi", 32'(mosi_cap[15:8]), 32'h12);
    check("rd12_no_we", wr_cnt, 1);
    repeat (3) @(negedge clk_i);
    check("rd12_rdata_held", 32'(rsp_rdata_o), 32'h3C);

    // 3: back-to-back writes with req_valid_i held
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    base = wr_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h21; req_wdata_i = 8'h11;
    wait_ready("b2b1");
    @(posedge clk_i);
    #1 req_addr_i = 7'h22; req_wdata_i = 8'h22;
    n = 0;
    while (cs_o !== 1'b1 && n < BOUND) begin @(negedge clk_i); n++; end
    check("b2b_cs_rise_timeout", 32'(n < BOUND), 32'd1);
    hi = 0; rdy_hi = 0;
    while (cs_o === 1'b1 && hi < 50) begin
      hi++;
      if (req_ready_o) rdy_hi++;
      @(negedge clk_i);
    end
    check("b2b_cs_gap", hi, CLK_DIV);
    check("b2b_ready_in_gap", rdy_hi, 0);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    wait_ready("b2b2");
    check("b2b_wr_cnt", wr_cnt, base + 2);
    check("b2b_order0", 32'(wr_addr_q[base]), 32'h21);
    check("b2b_order1", 32'(wr_addr_q[base+1]), 32'h22);
    check("b2b_mem21", 32'(mem[7'h21]), 32'h11);
    check("b2b_mem22", 32'(mem[7'h22]), 32'h22);

    // 4: reset after the 7th SCLK rise of a write
    base = wr_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h40; req_wdata_i = 8'h77;
    wait_ready("abort");
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    n = 0;
    while (p_cnt < 7 && n < BOUND) begin @(negedge clk_i); n++; end
    check("abort_rise7_timeout", 32'(n < BOUND), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_cs", 32'(cs_o), 32'd1);
    check("abort_sclk", 32'(sclk_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ready", 32'(req_ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("abort_no_we", wr_cnt, base);
    check("abort_mem", 32'(mem[7'h40]), 32'h00);
    send("wr40", 1'b1, 7'h40, 8'h99, 8'h00);
    check("wr40_mem", 32'(mem[7'h40]), 32'h99);
    check("wr40_wr_cnt", wr_cnt, base + 1);

    // 5: req_* scrambled every cycle after accept, valid held into rsp cycle
    exp_q.push_back(8'h00);
    base = wr_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h33; req_wdata_i = 8'h5A;
    wait_ready("scr");
    @(posedge clk_i);
    n = 0; seen = 1'b0; extra_acc = 0;
    while (!seen && n < BOUND) begin
      @(negedge clk_i);
      n++;
      req_we_i    = 1'($urandom_range(0, 1));
      req_addr_i  = 7'($urandom_range(0, 127));
      req_wdata_i = 8'($urandom_range(0, 255));
      if (req_ready_o) extra_acc++;
      if (rsp_valid_o) seen = 1'b1;
    end
    check("scr_rsp_timeout", 32'(seen), 32'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    check("scr_simul_not_accepted", 32'(dbg_state_o), 32'(GAP));
    @(negedge clk_i);
    wait_ready("scr_end");
    check("scr_extra_accept", extra_acc, 0);
    check("scr_mosi", 32'(mosi_cap), 32'hB35A);
    check("scr_mem", 32'(mem[7'h33]), 32'h5A);
    check("scr_wr_cnt", wr_cnt, base + 1);

    // 6: reads of all-ones and all-zeros
    send("rd7f", 1'b0, 7'h7F, 8'h00, 8'hFF);
    check("rd7f_rdata", 32'(rsp_rdata_o), 32'hFF);
    send("rd00", 1'b0, 7'h00, 8'hFF, 8'h00);
    check("rd00_rdata", 32'(rsp_rdata_o), 32'h00);

    repeat (4) @(negedge clk_i);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
